// File: rtl/controller_mc.sv
// ---------------------------------------------------------------------------
// controller_mc
// Multi-cycle control FSM for an RV32I subset (lw, sw, R-type, I-type ALU,
// beq/bne/blt/bge, jal, jalr, lui). It drives every enable and mux of a
// shared-memory, single-ALU datapath with IR, OldPC, ALUOut and Data
// registers. It also counts retired instructions and halts on an
// unsupported opcode.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   op, func3, func7      fields of the latched instruction register
//   Zero, lt              ALU flags used by conditional branches
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl datapath mux/ALU controls
//   done                  high while halted on an unsupported opcode
//   instr_cnt             retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module controller_mc #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             Zero,
    input  logic             lt,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_LUI    = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JALR   = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    // Immediate format selected purely from the opcode.
    function automatic logic [2:0] imm_decode(input logic [6:0] opc);
        logic [2:0] imm;
        case (opc)
            OP_SW:   imm = 3'b001;
            OP_B:    imm = 3'b010;
            OP_JAL:  imm = 3'b011;
            OP_LUI:  imm = 3'b100;
            default: imm = 3'b000;
        endcase
        return imm;
    endfunction

    // ALUOp plus instruction fields to the ALU operation code.
    function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                              input logic [2:0] f3,
                                              input logic [6:0] f7,
                                              input logic       is_r);
        logic [2:0] ctl;
        case (aluop)
            2'b00: ctl = 3'b000;
            2'b01: ctl = 3'b001;
            2'b11: ctl = 3'b100;
            2'b10: begin
                case (f3)
                    // Only register-register ops use func7 to pick subtract;
                    // an immediate's upper bits must not turn addi into sub.
                    3'b000:  ctl = (is_r && (f7 == 7'b0100000)) ? 3'b001 : 3'b000;
                    3'b111:  ctl = 3'b010;
                    3'b110:  ctl = 3'b011;
                    3'b100:  ctl = 3'b111;
                    3'b010:  ctl = 3'b101;
                    default: ctl = 3'b000;
                endcase
            end
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    // Branch decision from func3 and the flags of the rs1-rs2 compare.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       z,
                                          input logic       l);
        logic tk;
        case (f3)
            3'b000:  tk = z;
            3'b001:  tk = ~z;
            3'b100:  tk = l;
            3'b101:  tk = ~l;
            default: tk = 1'b0;
        endcase
        return tk;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    logic             pc_write;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             halted;

    // State and retired-instruction counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and Moore control decode.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures OldPC+imm, the branch/jal target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JUMP;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_b = 2'b01;
                alu_op    = 2'b11;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                // PC is loaded from ALUOut (target computed in DECODE).
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = branch_taken(func3, Zero, lt);
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JUMP;
            end
            S_JUMP: begin
                // PC <= ALUOut target while the ALU forms the link OldPC+4.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Retired-instruction counter update, wrapping naturally.
    always_comb begin
        if (retire) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output gating: nothing may write while reset is held.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = 3'b000;
        done       = 1'b0;
        if (rst) begin
            PCWrite = 1'b0;
        end else begin
            PCWrite    = pc_write;
            AdrSrc     = adr_src;
            MemWrite   = mem_write;
            IRWrite    = ir_write;
            RegWrite   = reg_write;
            ResultSrc  = result_src;
            ALUSrcA    = alu_src_a;
            ALUSrcB    = alu_src_b;
            ImmSrc     = imm_decode(op);
            ALUControl = alu_decode(alu_op, func3, func7, (op == OP_R));
            done       = halted;
        end
    end

    assign instr_cnt = cnt_q;

endmodule
